// File: rtl/reg_slice_pkg.sv
// -----------------------------------------------------------------------------
// reg_slice_pkg
// Shared constants and helpers for the register-slice pipeline.
//   STAGES_MAX : largest supported number of cascaded skid stages
//   clog2()    : ceiling log2, used to size the occupancy counter
// -----------------------------------------------------------------------------
package reg_slice_pkg;

  localparam int STAGES_MAX = 8;

  // Ceiling log2 of value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 32'sd0;
    rem = value - 32'sd1;
    while (rem > 32'sd0) begin
      res = res + 32'sd1;
      rem = rem >>> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_slice_pipe_if.sv
// -----------------------------------------------------------------------------
// reg_slice_pipe_if
// Valid/ready streaming channel carrying one DW-bit word.
//   valid : producer has a word
//   ready : consumer can take the word
//   data  : the word
// Modports: master = producer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface reg_slice_pipe_if #(
  parameter int DW = 32
);

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/reg_slice_stage.sv
// -----------------------------------------------------------------------------
// reg_slice_stage
// One skid-buffer register slice: a main register feeding the output and a
// skid register that catches the word accepted while main is stalled.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready/in_data    : upstream channel
//   out_valid/out_ready/out_data : downstream channel
// in_ready comes only from the skid-valid flop, so no combinational path
// runs from out_ready back to in_ready.
// -----------------------------------------------------------------------------
module reg_slice_stage
  import reg_slice_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DATA_RST = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          main_v_r;
  logic          skid_v_r;
  logic [DW-1:0] main_d_r;
  logic [DW-1:0] skid_d_r;

  logic          main_v_nxt_s;
  logic          skid_v_nxt_s;
  logic [DW-1:0] main_d_nxt_s;
  logic [DW-1:0] skid_d_nxt_s;

  logic          in_fire_s;
  logic          load_main_s;

  assign in_ready  = ~skid_v_r;
  assign out_valid = main_v_r;
  assign out_data  = main_d_r;

  assign in_fire_s   = in_valid & ~skid_v_r;
  assign load_main_s = ~main_v_r | out_ready;

  // Next-state for main and skid: main refills from skid first, then input.
  always_comb begin
    main_v_nxt_s = main_v_r;
    skid_v_nxt_s = skid_v_r;
    main_d_nxt_s = main_d_r;
    skid_d_nxt_s = skid_d_r;
    if (load_main_s) begin
      if (skid_v_r) begin
        // in_ready is low here, so no new word can arrive this cycle
        main_v_nxt_s = 1'b1;
        main_d_nxt_s = skid_d_r;
        skid_v_nxt_s = 1'b0;
      end else begin
        main_v_nxt_s = in_fire_s;
        if (in_fire_s) begin
          main_d_nxt_s = in_data;
        end else begin
          main_d_nxt_s = main_d_r;
        end
      end
    end else begin
      if (in_fire_s) begin
        skid_v_nxt_s = 1'b1;
        skid_d_nxt_s = in_data;
      end else begin
        skid_v_nxt_s = skid_v_r;
      end
    end
  end

  // Valid flags: always cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_r <= 1'b0;
      skid_v_r <= 1'b0;
    end else begin
      main_v_r <= main_v_nxt_s;
      skid_v_r <= skid_v_nxt_s;
    end
  end

  generate
    if (DATA_RST != 0) begin : g_data_rst
      // Data registers with async clear.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_d_r <= {DW{1'b0}};
          skid_d_r <= {DW{1'b0}};
        end else begin
          main_d_r <= main_d_nxt_s;
          skid_d_r <= skid_d_nxt_s;
        end
      end
    end else begin : g_data_norst
      // Data registers without reset; contents are qualified by the valid flags.
      always_ff @(posedge clk) begin
        main_d_r <= main_d_nxt_s;
        skid_d_r <= skid_d_nxt_s;
      end
    end
  endgenerate

endmodule

// File: rtl/reg_slice_pipe.sv
// -----------------------------------------------------------------------------
// reg_slice_pipe
// STAGES cascaded skid register slices with an occupancy counter.
//   clk, rst_n : clock, async active-low reset
//   s_if       : upstream channel (slave modport)
//   m_if       : downstream channel (master modport), driven from the last
//                stage's main register
//   o_count    : registered number of words held (0 .. 2*STAGES)
// -----------------------------------------------------------------------------
module reg_slice_pipe
  import reg_slice_pkg::*;
#(
  parameter int DW       = 32,
  parameter int STAGES   = 2,
  parameter int DATA_RST = 0,
  localparam int CW      = clog2(2 * STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_slice_pipe_if.slave   s_if,
  reg_slice_pipe_if.master  m_if,
  output logic [CW-1:0]     o_count
);

  // Link g connects stage g-1 to stage g; link 0 is the input, link STAGES the output.
  logic [STAGES:0]         vld_s;
  logic [STAGES:0]         rdy_s;
  logic [STAGES:0][DW-1:0] dat_s;

  logic          s_fire_s;
  logic          m_fire_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;

  assign vld_s[0]      = s_if.valid;
  assign dat_s[0]      = s_if.data;
  assign s_if.ready    = rdy_s[0];
  assign m_if.valid    = vld_s[STAGES];
  assign m_if.data     = dat_s[STAGES];
  assign rdy_s[STAGES] = m_if.ready;

  generate
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
      reg_slice_stage #(
        .DW       (DW),
        .DATA_RST (DATA_RST)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (vld_s[g]),
        .in_ready  (rdy_s[g]),
        .in_data   (dat_s[g]),
        .out_valid (vld_s[g+1]),
        .out_ready (rdy_s[g+1]),
        .out_data  (dat_s[g+1])
      );
    end
  endgenerate

  assign s_fire_s = vld_s[0] & rdy_s[0];
  assign m_fire_s = vld_s[STAGES] & rdy_s[STAGES];

  // Occupancy next-state: simultaneous in and out leave the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({s_fire_s, m_fire_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign o_count = count_r;

endmodule

// File: tb/tb_reg_slice_pipe.sv
// -----------------------------------------------------------------------------
// tb_reg_slice_pipe
// Scoreboard bench for reg_slice_pipe with DW=16, STAGES=2, DATA_RST=1.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge, where handshakes are decided and the scoreboard is updated.
// -----------------------------------------------------------------------------
module tb_reg_slice_pipe;
  import reg_slice_pkg::*;

  localparam int DW = 16;
  localparam int ST = 2;
  localparam int CW = clog2(2 * ST + 1);

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] o_count;

  reg_slice_pipe_if #(.DW(DW)) s_if ();
  reg_slice_pipe_if #(.DW(DW)) m_if ();

  reg_slice_pipe #(
    .DW       (DW),
    .STAGES   (ST),
    .DATA_RST (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_if    (s_if),
    .m_if    (m_if),
    .o_count (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  int out_cnt  = 0;
  logic [DW-1:0] exp_q[$];
  logic last_s_fire;
  logic last_m_fire;
  logic last_sready;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, sample on falling edge, update scoreboard, advance.
  task automatic cycle(input logic sv, input logic [DW-1:0] sd, input logic mr);
    s_if.valid  = sv;
    s_if.data   = sd;
    m_if.ready  = mr;
    @(negedge clk);
    check_eq("count_vs_model", 32'(o_count), 32'(exp_q.size()));
    if (exp_q.size() == 0) check_eq("empty_mvalid", 32'(m_if.valid), 32'd0);
    if (exp_q.size() == 2 * ST) check_eq("full_sready", 32'(s_if.ready), 32'd0);
    last_sready = s_if.ready;
    last_s_fire = sv & s_if.ready;
    last_m_fire = m_if.valid & mr;
    if (last_m_fire && exp_q.size() > 0) begin
      check_eq("data_order", 32'(m_if.data), 32'(exp_q.pop_front()));
      out_cnt++;
    end
    if (last_s_fire) begin
      exp_q.push_back(sd);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) cycle(1'b0, 16'h0000, 1'b1);
    check_eq("drain_count", 32'(o_count), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int c0;
    int first_acc;
    int first_out;
    int last_out;
    int a0;
    int o0;
    logic [DW-1:0] hold_d;
    logic got;

    s_if.valid = 1'b0;
    s_if.data  = 16'h0000;
    m_if.ready = 1'b0;
    rst_n      = 1'b0;
    #2;
    check_eq("rst_mvalid", 32'(m_if.valid), 32'd0);
    check_eq("rst_count", 32'(o_count), 32'd0);
    check_eq("rst_sready", 32'(s_if.ready), 32'd1);
    check_eq("rst_mdata", 32'(m_if.data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stream: 16 words back-to-back with m_ready held high.
    k = 0; first_acc = -1; first_out = -1; last_out = -1; o0 = out_cnt;
    for (int i = 0; i < 40; i++) begin
      c0 = cyc;
      cycle(k < 16, 16'(k + 1), 1'b1);
      if (k < 16) check_eq("stream_sready", 32'(last_sready), 32'd1);
      check_eq("stream_count_le2", 32'(o_count <= 3'(2)), 32'd1);
      if (last_s_fire) begin
        k++;
        if (first_acc < 0) first_acc = c0;
      end
      if (last_m_fire) begin
        if (first_out < 0) first_out = c0;
        last_out = c0;
      end
    end
    check_eq("stream_latency", 32'(first_out - first_acc), 32'd2);
    check_eq("stream_outs", 32'(out_cnt - o0), 32'd16);
    check_eq("stream_no_bubble", 32'(last_out - first_out), 32'd15);

    // Fill: stalled output accepts exactly 2*ST words.
    a0 = acc_cnt; k = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 16'hA000 + 16'(k), 1'b0);
      if (last_s_fire) k++;
    end
    check_eq("fill_accepts", 32'(acc_cnt - a0), 32'd4);
    check_eq("fill_sready", 32'(s_if.ready), 32'd0);
    check_eq("fill_count", 32'(o_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 16'h0000, 1'b1);
      check_eq("fill_drain_fire", 32'(last_m_fire), 32'd1);
    end
    check_eq("fill_empty", 32'(o_count), 32'd0);

    // Stall: held output word stays stable.
    cycle(1'b1, 16'hBEEF, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle(1'b0, 16'h0000, 1'b0);
      got = m_if.valid;
    end
    check_eq("stall_valid_seen", 32'(got), 32'd1);
    hold_d = m_if.data;
    check_eq("stall_first_data", 32'(hold_d), 32'hBEEF);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 16'h0000, 1'b0);
      check_eq("stall_mvalid", 32'(m_if.valid), 32'd1);
      check_eq("stall_mdata", 32'(m_if.data), 32'(hold_d));
    end
    drain();

    // Full boundary: one-cycle m_ready pulse while full and s_valid high.
    k = 0;
    for (int i = 0; i < 8 && k < 4; i++) begin
      cycle(1'b1, 16'hC000 + 16'(k), 1'b0);
      if (last_s_fire) k++;
    end
    check_eq("fb_count4", 32'(o_count), 32'd4);
    cycle(1'b1, 16'hC004, 1'b1);
    check_eq("fb_no_accept", 32'(last_s_fire), 32'd0);
    check_eq("fb_m_fire", 32'(last_m_fire), 32'd1);
    check_eq("fb_count3", 32'(o_count), 32'd3);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      cycle(1'b1, 16'hC004, 1'b0);
      got = last_s_fire;
    end
    check_eq("fb_reaccept", 32'(got), 32'd1);
    check_eq("fb_count4_again", 32'(o_count), 32'd4);
    drain();

    // Reset mid-operation with three words held.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'hD000 + 16'(i), 1'b0);
    s_if.valid = 1'b0;
    check_eq("rstm_count3", 32'(o_count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstm_mvalid", 32'(m_if.valid), 32'd0);
    check_eq("rstm_count", 32'(o_count), 32'd0);
    check_eq("rstm_sready", 32'(s_if.ready), 32'd1);
    check_eq("rstm_mdata", 32'(m_if.data), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    cycle(1'b1, 16'h5A5A, 1'b1);
    check_eq("rstm_accept", 32'(last_s_fire), 32'd1);
    first_out = -1;
    for (int i = 0; i < 6 && first_out < 0; i++) begin
      a0 = cyc;
      if (cyc - c0 >= 1) begin
        s_if.valid = 1'b0;
      end
      cycle(1'b0, 16'h0000, 1'b1);
      if (last_m_fire) begin
        first_out = a0;
        check_eq("rstm_word", 32'(m_if.data), 32'h5A5A);
      end
    end
    check_eq("rstm_latency", 32'(first_out - c0), 32'd2);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/reg_slice_pipe.md
REG_SLICE_PIPE -- requirements
Module: reg_slice_pipe

Interface
REQ-001 Parameter DW, default 32: data width in bits, legal range 1..1024.
REQ-002 Parameter STAGES, default 2: number of cascaded register-slice stages, legal range 1..8.
REQ-003 Parameter DATA_RST, default 0: 1 = data registers async-cleared to 0; 0 = data registers have no reset.
REQ-004 Localparam CW = clog2(2*STAGES+1): width of the occupancy count.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 s_valid  input  1  upstream word valid.
REQ-008 s_ready  output  1  pipe can accept a word.
REQ-009 s_data  input  DW  upstream word.
REQ-010 m_valid  output  1  downstream word valid.
REQ-011 m_ready  input  1  downstream accepts the word.
REQ-012 m_data  output  DW  downstream word.
REQ-013 o_count  output  CW  number of words currently held in the pipe.

Function
REQ-014 A transfer occurs on a rising edge where valid and ready are both 1, on either side.
REQ-015 Each stage holds a main register and a skid register (valid bit plus DW data each), so capacity is 2 per stage and 2*STAGES in total.
REQ-016 Each stage's upstream ready is the inverse of its registered skid-valid bit, so it has no combinational path from m_ready.
REQ-017 When a stage's main register is empty or its downstream handshake fires, main loads from skid if skid is valid, otherwise from the input handshake.
REQ-018 When main is full and not draining and the input handshake fires, the word goes to skid; skid empties into main on the next drain.
REQ-019 Word order is strictly preserved; words are never dropped or duplicated.
REQ-020 m_valid and m_data are driven directly from the last stage's main register.
REQ-021 Latency from an s-side transfer into an empty pipe to m_valid=1 is exactly STAGES cycles.
REQ-022 Throughput is one word per cycle sustained while m_ready=1.
REQ-023 While m_valid=1 and m_ready=0, m_data and m_valid stay stable.
REQ-024 o_count is registered: +1 on an s-side transfer only, -1 on an m-side transfer only, unchanged when both or neither occur.
REQ-025 When full (o_count = 2*STAGES), s_ready=0; an m-side transfer in that cycle decrements o_count and s_ready returns to 1 by the cycle after the stage-0 skid drains.
REQ-026 When empty (o_count=0), m_valid=0.
REQ-027 o_count never exceeds 2*STAGES and never wraps below 0.

Reset
REQ-028 While rst_n=0: all valid bits =0, m_valid=0, o_count=0, s_ready=1.
REQ-029 m_data=0 during reset when DATA_RST=1; m_data is unspecified when DATA_RST=0.
REQ-030 Reset asserted mid-operation discards all held words immediately and asynchronously.
REQ-031 The first word accepted after reset release emerges STAGES cycles later with its own value.

Structure
REQ-032 Package reg_slice_pkg holds STAGES_MAX=8 and the count-width function clog2.
REQ-033 One sub-module, reg_slice_stage (DW, DATA_RST), implements a single skid stage; the top generates STAGES instances plus the o_count counter.

Verification
REQ-034 Stream test, DW=16 STAGES=2 m_ready=1: send 0x0001..0x0010 back-to-back -> first m_valid 2 cycles after first accept, same order, no bubbles, o_count<=2.
REQ-035 Fill test: m_ready=0 and push 0xA000.. -> exactly 4 accepted, s_ready=0, o_count=4; then m_ready=1 -> 0xA000..0xA003 out over 4 cycles, o_count=0.
REQ-036 Stall test: hold m_valid=1 with m_ready=0 for 5 cycles -> m_data constant each cycle.
REQ-037 Full-boundary test: o_count=4, s_valid=1, one-cycle m_ready pulse -> no s-side accept that cycle, o_count=3, next word accepted once s_ready=1, o_count=4.
REQ-038 Reset test: drop rst_n with o_count=3 -> m_valid=0 and o_count=0 before the next clock, s_ready=1; push 0x5A5A after release -> 0x5A5A out 2 cycles later; with DATA_RST=1, m_data=0 during reset.
REQ-039 Random test: random s_valid/m_ready at 50% for 10000 cycles against a scoreboard -> order and data match, o_count always equals the scoreboard depth.
